// File: rtl/mdig_pkg.sv
// Shared types, mode constants and width helpers for the
// multiply/divide index generator.
package mdig_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_DOUBLE = 1'b1;

    function automatic int col_w(input int j, input int a);
        return $clog2(j * a);
    endfunction

    function automatic int row_w(input int j, input int a);
        return $clog2(j * j * (a - 1) * (a - 1) + 1);
    endfunction

    // Smallest symbol that differs from the excluded one.
    function automatic int first_sym(input int excl);
        return (excl == 0) ? 1 : 0;
    endfunction

endpackage

// File: rtl/mdig_skip_counter.sv
// Successor logic for a 0..A-1 symbol counter that never lands on
// the excluded value; wrap flags that the sequence is exhausted.
module mdig_skip_counter
    import mdig_pkg::*;
#(
    parameter int A      = 4,
    parameter int AWIDTH = $clog2(A) + 1
) (
    input  logic [AWIDTH-1:0] value,
    input  logic [AWIDTH-1:0] excl,
    output logic [AWIDTH-1:0] first,
    output logic [AWIDTH-1:0] next,
    output logic              wrap
);

    logic [AWIDTH:0] step1;
    logic [AWIDTH:0] step2;
    logic [AWIDTH:0] cand;

    always_comb begin
        first = AWIDTH'(first_sym(int'(excl)));
        step1 = {1'b0, value} + (AWIDTH+1)'(1);
        step2 = {1'b0, value} + (AWIDTH+1)'(2);
        cand  = (step1 == {1'b0, excl}) ? step2 : step1;
        wrap  = (int'(cand) >= A);
        next  = wrap ? first : cand[AWIDTH-1:0];
    end

endmodule

// File: rtl/multi_divi_index_gen_axis.sv
// Streams single/double flip candidate column descriptors over ready/valid.
// Optional MDIG_ABORT_EN adds an abort_gen input that cancels a run.
module multi_divi_index_gen_axis
    import mdig_pkg::*;
#(
    parameter int J       = 14,
    parameter int A       = 4,
    parameter int AWIDTH  = $clog2(A) + 1,
    parameter int J_WIDTH = $clog2(J) + 1,
    parameter int COL_W   = col_w(J, A),
    parameter int ROW_W   = row_w(J, A)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [J*AWIDTH-1:0]   x_initial,
    input  logic                  x_initial_tvalid,
    input  logic                  start_gen,
    input  logic [J_WIDTH-1:0]    J_index,
    input  logic                  mode,
`ifdef MDIG_ABORT_EN
    input  logic                  abort_gen,
`endif
    output logic [COL_W-1:0]      mult_col_idx1,
    output logic [COL_W-1:0]      mult_col_idx2,
    output logic [COL_W-1:0]      divi_col_idx1,
    output logic [COL_W-1:0]      divi_col_idx2,
    output logic [ROW_W-1:0]      row_idx,
    output logic                  idx2_valid,
    output logic                  index_out_tvalid,
    input  logic                  index_out_tready,
    output logic                  index_out_tlast,
    output logic                  busy,
    output logic                  done
);

    localparam int PW = (J > 1) ? $clog2(J) : 1;
    localparam int I1 = (J > 1) ? 1 : 0;

    state_t             state;
    logic [AWIDTH-1:0]  x_q     [J];
    logic [AWIDTH-1:0]  x_clamp [J];
    logic [J_WIDTH-1:0] n;
    logic [J_WIDTH-1:0] n_in;
    logic [J_WIDTH-1:0] n_m1;
    logic [J_WIDTH-1:0] n_m2;
    logic               mode_r;
    logic               tvalid;
    logic               empty;
    logic [ROW_W-1:0]   row;
    logic [PW-1:0]      p;
    logic [PW-1:0]      q;
    logic [PW-1:0]      p_inc;
    logic [PW-1:0]      p_inc2;
    logic [PW-1:0]      q_inc;
    logic [AWIDTH-1:0]  a;
    logic [AWIDTH-1:0]  b;
    logic [AWIDTH-1:0]  a_d;
    logic [AWIDTH-1:0]  b_d;
    logic [AWIDTH-1:0]  a_excl;
    logic [AWIDTH-1:0]  b_excl;
    logic [AWIDTH-1:0]  a_first;
    logic [AWIDTH-1:0]  b_first;
    logic [AWIDTH-1:0]  a_next;
    logic [AWIDTH-1:0]  b_next;
    logic               a_wrap;
    logic               b_wrap;
    logic [AWIDTH-1:0]  x_p1;
    logic [AWIDTH-1:0]  x_q1;
    logic [AWIDTH-1:0]  x_p2;
    logic               is_last;
    logic               start_ok;
    logic               adv;

    mdig_skip_counter #(.A(A), .AWIDTH(AWIDTH)) u_a (
        .value (a),
        .excl  (a_excl),
        .first (a_first),
        .next  (a_next),
        .wrap  (a_wrap)
    );

    mdig_skip_counter #(.A(A), .AWIDTH(AWIDTH)) u_b (
        .value (b),
        .excl  (b_excl),
        .first (b_first),
        .next  (b_next),
        .wrap  (b_wrap)
    );

    always_comb begin
        for (int i = 0; i < J; i++) begin
            x_clamp[i] = (int'(x_initial[i*AWIDTH +: AWIDTH]) >= A) ?
                         AWIDTH'(A - 1) : x_initial[i*AWIDTH +: AWIDTH];
        end
    end

    always_comb begin
        n_in   = (int'(J_index) > J) ? J_WIDTH'(J) : J_index;
        empty  = (n_in == '0) ||
                 ((mode == MODE_DOUBLE) && (n_in < J_WIDTH'(2)));
        n_m1   = n - J_WIDTH'(1);
        n_m2   = n - J_WIDTH'(2);
        p_inc  = p + PW'(1);
        p_inc2 = p + PW'(2);
        q_inc  = q + PW'(1);
        x_p1   = (int'(p) + 1 < J) ? x_q[p_inc]  : '0;
        x_q1   = (int'(q) + 1 < J) ? x_q[q_inc]  : '0;
        x_p2   = (int'(p) + 2 < J) ? x_q[p_inc2] : '0;
        // At start the counters must see the vector being loaded this cycle.
        if (state == IDLE) begin
            a_excl = x_initial_tvalid ? x_clamp[0]  : x_q[0];
            b_excl = x_initial_tvalid ? x_clamp[I1] : x_q[I1];
        end else begin
            a_excl = x_q[p];
            b_excl = x_q[q];
        end
        if (mode_r == MODE_SINGLE) begin
            is_last = tvalid && (J_WIDTH'(p) == n_m1) && a_wrap;
        end else begin
            is_last = tvalid && (J_WIDTH'(q) == n_m1) &&
                      (J_WIDTH'(p) == n_m2) && a_wrap && b_wrap;
        end
    end

    assign start_ok = (state == IDLE) && start_gen;

`ifdef MDIG_ABORT_EN
    assign adv = (state == RUN) && tvalid && index_out_tready &&
                 !is_last && !abort_gen;
`else
    assign adv = (state == RUN) && tvalid && index_out_tready && !is_last;
`endif

    always_comb begin
        a_d = a;
        b_d = b;
        if (start_ok) begin
            a_d = a_first;
            b_d = (mode == MODE_DOUBLE) ? b_first : '0;
        end else if (adv) begin
            if (mode_r == MODE_SINGLE) begin
                a_d = a_wrap ? AWIDTH'(first_sym(int'(x_p1))) : a_next;
            end else if (!b_wrap) begin
                b_d = b_next;
            end else if (!a_wrap) begin
                a_d = a_next;
                b_d = b_next;
            end else if (J_WIDTH'(q) != n_m1) begin
                a_d = a_next;
                b_d = AWIDTH'(first_sym(int'(x_q1)));
            end else begin
                a_d = AWIDTH'(first_sym(int'(x_p1)));
                b_d = AWIDTH'(first_sym(int'(x_p2)));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            for (int i = 0; i < J; i++) x_q[i] <= '0;
            n      <= '0;
            mode_r <= MODE_SINGLE;
            tvalid <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            row    <= '0;
            p      <= '0;
            q      <= '0;
            a      <= '0;
            b      <= '0;
        end else begin
            done <= 1'b0;
            a    <= a_d;
            b    <= b_d;
            unique case (state)
                IDLE: begin
                    if (x_initial_tvalid) begin
                        for (int i = 0; i < J; i++) x_q[i] <= x_clamp[i];
                    end
                    if (start_gen) begin
                        n      <= n_in;
                        mode_r <= mode;
                        p      <= '0;
                        q      <= (mode == MODE_DOUBLE) ? PW'(1) : '0;
                        row    <= '0;
                        tvalid <= !empty;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
`ifdef MDIG_ABORT_EN
                    if (abort_gen) begin
                        tvalid <= 1'b0;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end else
`endif
                    if (!tvalid) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end else if (index_out_tready) begin
                        row <= row + ROW_W'(1);
                        if (is_last) begin
                            tvalid <= 1'b0;
                            busy   <= 1'b0;
                            state  <= DONE;
                        end else if (mode_r == MODE_SINGLE) begin
                            if (a_wrap) p <= p_inc;
                        end else if (a_wrap && b_wrap) begin
                            if (J_WIDTH'(q) != n_m1) begin
                                q <= q_inc;
                            end else begin
                                p <= p_inc;
                                q <= p_inc2;
                            end
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mult_col_idx1 = COL_W'(int'(p) * A + int'(a));
        divi_col_idx1 = COL_W'(int'(p) * A + int'(x_q[p]));
        mult_col_idx2 = '0;
        divi_col_idx2 = '0;
        if (mode_r == MODE_DOUBLE) begin
            mult_col_idx2 = COL_W'(int'(q) * A + int'(b));
            divi_col_idx2 = COL_W'(int'(q) * A + int'(x_q[q]));
        end
    end

    assign row_idx          = row;
    assign idx2_valid       = mode_r;
    assign index_out_tvalid = tvalid;
    assign index_out_tlast  = is_last;

endmodule

// File: tb/tb_multi_divi_index_gen_axis.sv
// Scoreboard bench for multi_divi_index_gen_axis (J=14, A=4).
module tb_multi_divi_index_gen_axis;

    localparam int J  = 14;
    localparam int A  = 4;
    localparam int AW = 3;
    localparam int JW = 5;
    localparam int CW = 6;
    localparam int RW = 11;

    logic            clk = 1'b0;
    logic            rst;
    logic [J*AW-1:0] x_initial;
    logic            x_initial_tvalid;
    logic            start_gen;
    logic [JW-1:0]   J_index;
    logic            mode;
    logic            abort_gen;
    logic [CW-1:0]   mult_col_idx1;
    logic [CW-1:0]   mult_col_idx2;
    logic [CW-1:0]   divi_col_idx1;
    logic [CW-1:0]   divi_col_idx2;
    logic [RW-1:0]   row_idx;
    logic            idx2_valid;
    logic            index_out_tvalid;
    logic            index_out_tready;
    logic            index_out_tlast;
    logic            busy;
    logic            done;

    always #5 clk = ~clk;

    multi_divi_index_gen_axis #(.J(J), .A(A)) dut (
        .clk              (clk),
        .rst              (rst),
        .x_initial        (x_initial),
        .x_initial_tvalid (x_initial_tvalid),
        .start_gen        (start_gen),
        .J_index          (J_index),
        .mode             (mode),
`ifdef MDIG_ABORT_EN
        .abort_gen        (abort_gen),
`endif
        .mult_col_idx1    (mult_col_idx1),
        .mult_col_idx2    (mult_col_idx2),
        .divi_col_idx1    (divi_col_idx1),
        .divi_col_idx2    (divi_col_idx2),
        .row_idx          (row_idx),
        .idx2_valid       (idx2_valid),
        .index_out_tvalid (index_out_tvalid),
        .index_out_tready (index_out_tready),
        .index_out_tlast  (index_out_tlast),
        .busy             (busy),
        .done             (done)
    );

    typedef struct {
        int m1;
        int m2;
        int d1;
        int d2;
        int row;
        bit last;
        bit i2;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   ncyc = 0;
    int   start_cyc = -1;
    int   last_cyc = -1;
    int   done_cnt = 0;
    int   xfer_cnt = 0;
    int   tlast_cnt = 0;
    int   bp_mode = 0;
    bit   first_pend = 0;
    bit   held = 0;
    logic [4*CW+RW:0] h_vec;

    task automatic chk(input bit ok, input string nm, input int act, input int want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    // Reference: enumerate candidates directly from the flip rules.
    task automatic model(input logic [J*AW-1:0] xi, input int jidx,
                         input bit md, output int cnt);
        int   n;
        int   xs[J];
        exp_t e;
        exp_t tmp[$];
        n = (jidx > J) ? J : jidx;
        for (int i = 0; i < J; i++) begin
            xs[i] = int'(xi[i*AW +: AW]);
            if (xs[i] >= A) xs[i] = A - 1;
        end
        if (!md) begin
            for (int p = 0; p < n; p++)
                for (int a = 0; a < A; a++)
                    if (a != xs[p]) begin
                        e.m1 = p*A + a; e.d1 = p*A + xs[p];
                        e.m2 = 0; e.d2 = 0; e.i2 = 0; e.last = 0;
                        e.row = tmp.size();
                        tmp.push_back(e);
                    end
        end else begin
            for (int p = 0; p < n; p++)
                for (int q = p + 1; q < n; q++)
                    for (int a = 0; a < A; a++)
                        for (int b = 0; b < A; b++)
                            if (a != xs[p] && b != xs[q]) begin
                                e.m1 = p*A + a; e.d1 = p*A + xs[p];
                                e.m2 = q*A + b; e.d2 = q*A + xs[q];
                                e.i2 = 1; e.last = 0;
                                e.row = tmp.size();
                                tmp.push_back(e);
                            end
        end
        if (tmp.size() > 0) tmp[tmp.size()-1].last = 1;
        cnt = tmp.size();
        foreach (tmp[i]) sb.push_back(tmp[i]);
    endtask

    task automatic monitor();
        exp_t e;
        logic [4*CW+RW:0] cur;
        forever begin
            @(negedge clk);
            ncyc++;
            if (rst) begin
                held = 0;
                first_pend = 0;
                continue;
            end
            cur = {mult_col_idx1, mult_col_idx2, divi_col_idx1,
                   divi_col_idx2, row_idx, index_out_tlast};
            if (start_gen) begin
                start_cyc = ncyc;
                first_pend = 1;
            end
            if (done) begin
                done_cnt++;
                if (last_cyc >= 0) begin
                    chk(ncyc - last_cyc == 2, "done_latency", ncyc - last_cyc, 2);
                    last_cyc = -1;
                end
            end
            if (first_pend && index_out_tvalid) begin
                chk(ncyc - start_cyc == 1, "first_latency", ncyc - start_cyc, 1);
                first_pend = 0;
            end
            if (held) begin
                chk(index_out_tvalid == 1'b1, "hold_tvalid", int'(index_out_tvalid), 1);
                chk(cur == h_vec, "hold_data", int'(row_idx), int'(h_vec[RW:1]));
            end
            if (index_out_tvalid && index_out_tready) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "extra_xfer", int'(row_idx), -1);
                end else begin
                    e = sb.pop_front();
                    chk(int'(mult_col_idx1) == e.m1, "mult1", int'(mult_col_idx1), e.m1);
                    chk(int'(mult_col_idx2) == e.m2, "mult2", int'(mult_col_idx2), e.m2);
                    chk(int'(divi_col_idx1) == e.d1, "divi1", int'(divi_col_idx1), e.d1);
                    chk(int'(divi_col_idx2) == e.d2, "divi2", int'(divi_col_idx2), e.d2);
                    chk(int'(row_idx) == e.row, "row", int'(row_idx), e.row);
                    chk(index_out_tlast == e.last, "tlast", int'(index_out_tlast), int'(e.last));
                    chk(idx2_valid == e.i2, "idx2_valid", int'(idx2_valid), int'(e.i2));
                end
                xfer_cnt++;
                if (index_out_tlast) begin
                    tlast_cnt++;
                    last_cyc = ncyc;
                end
            end
            held  = index_out_tvalid && !index_out_tready && !abort_gen;
            h_vec = cur;
        end
    endtask

    task automatic drive_ready();
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode == 0)      index_out_tready = 1'b1;
            else if (bp_mode == 1) index_out_tready = 1'($urandom % 2);
            else                   index_out_tready = 1'b0;
        end
    endtask

    task automatic kick(input logic [J*AW-1:0] xi, input int jidx, input bit md);
        done_cnt = 0; xfer_cnt = 0; tlast_cnt = 0;
        @(posedge clk); #1;
        x_initial = xi; x_initial_tvalid = 1'b1;
        J_index = JW'(jidx); mode = md; start_gen = 1'b1;
        @(posedge clk); #1;
        x_initial_tvalid = 1'b0; start_gen = 1'b0;
        chk(busy == 1'b1, "busy_run", int'(busy), 1);
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (done_cnt == 0 && k < 5000) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        chk(k < 5000, {nm, "_timeout"}, k, 5000);
        chk(done_cnt == 1, {nm, "_done_pulses"}, done_cnt, 1);
    endtask

    task automatic run(input logic [J*AW-1:0] xi, input int jidx,
                       input bit md, input int bpm, input string nm);
        int n;
        model(xi, jidx, md, n);
        bp_mode = bpm;
        kick(xi, jidx, md);
        wait_done(nm);
        chk(xfer_cnt == n, {nm, "_count"}, xfer_cnt, n);
        chk(tlast_cnt == ((n > 0) ? 1 : 0), {nm, "_tlast_count"}, tlast_cnt, (n > 0) ? 1 : 0);
        chk(sb.size() == 0, {nm, "_leftover"}, sb.size(), 0);
        sb.delete();
        #1;
        chk(busy == 1'b0, {nm, "_busy_idle"}, int'(busy), 0);
    endtask

    task automatic wait_row5(input string nm);
        int k;
        k = 0;
        while (!(index_out_tvalid && row_idx == RW'(5)) && k < 200) begin
            @(posedge clk); #2;
            k++;
        end
        chk(k < 200, {nm, "_row5_wait"}, k, 200);
    endtask

    logic [J*AW-1:0] xz;
    logic [J*AW-1:0] xa;
    logic [J*AW-1:0] xr;
    int              n_tmp;

    initial begin
        rst = 1'b1;
        x_initial = '0; x_initial_tvalid = 1'b0; start_gen = 1'b0;
        J_index = '0; mode = 1'b0; abort_gen = 1'b0;
        index_out_tready = 1'b1;
        fork
            monitor();
            drive_ready();
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk(index_out_tvalid == 1'b0, "rst_tvalid", int'(index_out_tvalid), 0);
        chk(index_out_tlast == 1'b0, "rst_tlast", int'(index_out_tlast), 0);
        chk(busy == 1'b0, "rst_busy", int'(busy), 0);
        chk(done == 1'b0, "rst_done", int'(done), 0);
        chk(mult_col_idx1 == '0, "rst_mult1", int'(mult_col_idx1), 0);
        chk(mult_col_idx2 == '0, "rst_mult2", int'(mult_col_idx2), 0);
        chk(divi_col_idx1 == '0, "rst_divi1", int'(divi_col_idx1), 0);
        chk(divi_col_idx2 == '0, "rst_divi2", int'(divi_col_idx2), 0);
        chk(row_idx == '0, "rst_row", int'(row_idx), 0);
        chk(idx2_valid == 1'b0, "rst_idx2", int'(idx2_valid), 0);
        rst = 1'b0;

        xz = '0;
        xa = '0;
        for (int i = 1; i < J; i += 2) xa[i*AW +: AW] = 3'd7;

        run(xz, 7, 1'b0, 0, "single7");
        run(xa, 7, 1'b0, 0, "clampsym");
        run(xz, 3, 1'b1, 0, "double3");
        run(xz, 7, 1'b0, 1, "backpressure");
        run(xz, 0, 1'b0, 0, "empty_n0");
        run(xz, 1, 1'b1, 0, "empty_d1");
        run(xz, 20, 1'b0, 0, "clamp_n20");

        // Asynchronous reset in the middle of a run.
        model(xz, 7, 1'b0, n_tmp);
        bp_mode = 0;
        kick(xz, 7, 1'b0);
        wait_row5("reset");
        rst = 1'b1;
        #1;
        chk(index_out_tvalid == 1'b0, "midrst_tvalid", int'(index_out_tvalid), 0);
        chk(busy == 1'b0, "midrst_busy", int'(busy), 0);
        chk(row_idx == '0, "midrst_row", int'(row_idx), 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        run(xa, 4, 1'b0, 0, "restart");

`ifdef MDIG_ABORT_EN
        model(xz, 7, 1'b0, n_tmp);
        bp_mode = 0;
        kick(xz, 7, 1'b0);
        wait_row5("abort");
        bp_mode = 2;
        index_out_tready = 1'b0;
        abort_gen = 1'b1;
        @(posedge clk); #2;
        abort_gen = 1'b0;
        chk(index_out_tvalid == 1'b0, "abort_tvalid", int'(index_out_tvalid), 0);
        wait_done("abort");
        chk(tlast_cnt == 0, "abort_tlast", tlast_cnt, 0);
        chk(xfer_cnt == 5, "abort_count", xfer_cnt, 5);
        sb.delete();
        bp_mode = 0;
`endif

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < J; i++) xr[i*AW +: AW] = 3'($urandom % 8);
            run(xr, int'($urandom % 21), 1'($urandom % 2), 1, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
